// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
// One adjust+shift step per clock. Valid/ready handshake on both sides.
//
// Ports:
//   clk_i      clock, all state updates on the rising edge
//   rst_i      asynchronous active-high reset
//   binary_i   unsigned binary operand (BinWidth bits), sampled on the accepting edge
//   valid_i    binary_i is valid
//   ready_o    block can accept an operand (IDLE)
//   bcd_o      packed BCD result, digit k at [4k+3:4k], digit 0 least significant
//   valid_o    bcd_o holds a completed result (DONE)
//   ready_i    consumer accepts the result
module bin2bcd_seq #(
    parameter int unsigned BinWidth  = 8,
    parameter int unsigned NumDigits = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [BinWidth-1:0]      binary_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [4*NumDigits-1:0]   bcd_o,
    output logic                     valid_o,
    input  logic                     ready_i
);

    localparam int unsigned CntW = $clog2(BinWidth + 1);
    localparam int unsigned BcdW = 4 * NumDigits;

    // Smallest digit count whose decimal range covers 2^w - 1.
    function automatic int unsigned min_digits(input int unsigned w);
        longint unsigned maxv;
        longint unsigned p;
        int unsigned     d;
        maxv = (64'd1 << w) - 64'd1;
        p    = 64'd10;
        d    = 1;
        while (p <= maxv) begin
            p = p * 64'd10;
            d = d + 1;
        end
        return d;
    endfunction

    generate
        if (BinWidth < 1 || BinWidth > 32) begin : g_bad_width
            $error("bin2bcd_seq: BinWidth must be in 1..32");
        end
        if (NumDigits < min_digits(BinWidth)) begin : g_bad_digits
            $error("bin2bcd_seq: NumDigits too small for BinWidth");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [BinWidth-1:0]      r_shift;
    logic [BcdW-1:0]          r_scratch;
    logic [CntW-1:0]          r_count;
    logic [BcdW-1:0]          r_bcd;

    logic [BcdW-1:0]          w_adj;
    logic [BcdW+BinWidth-1:0] w_cat_sh;
    logic                     w_last;

    // Add-3 on every scratch digit >= 5, then shift {scratch, shift} left by one.
    // The bit leaving the top digit is provably zero for legal NumDigits.
    always_comb begin
        w_adj = r_scratch;
        for (int unsigned k = 0; k < NumDigits; k++) begin
            if (r_scratch[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
            end
        end
        w_cat_sh = {w_adj, r_shift} << 1;
    end

    assign w_last = (r_count == CntW'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake outputs decode from state only.
    always_comb begin
        w_state_next = r_state;
        ready_o      = 1'b0;
        valid_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_count   <= '0;
            r_bcd     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_shift   <= binary_i;
                        r_scratch <= '0;
                        r_count   <= CntW'(BinWidth);
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_cat_sh[BcdW+BinWidth-1 -: BcdW];
                    r_shift   <= w_cat_sh[BinWidth-1:0];
                    r_count   <= r_count - CntW'(1);
                    if (w_last) begin
                        r_bcd <= w_cat_sh[BcdW+BinWidth-1 -: BcdW];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bcd_o = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: default (8b/3 digits), legacy (4b/2 digits)
// and wide (16b/5 digits) configurations against a decimal reference model.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance 0: default, 1: legacy, 2: wide
    logic [7:0]  bin0;
    logic [3:0]  bin1;
    logic [15:0] bin2;
    logic        vin0, vin1, vin2;
    logic        rin0, rin1, rin2;
    logic        rdy0, rdy1, rdy2;
    logic        vld0, vld1, vld2;
    logic [11:0] bcd0;
    logic [7:0]  bcd1;
    logic [19:0] bcd2;

    int unsigned bw[3] = '{8, 4, 16};
    int unsigned nd[3] = '{3, 2, 5};

    bin2bcd_seq u_def (
        .clk_i(clk), .rst_i(rst), .binary_i(bin0), .valid_i(vin0),
        .ready_o(rdy0), .bcd_o(bcd0), .valid_o(vld0), .ready_i(rin0)
    );

    bin2bcd_seq #(.BinWidth(4), .NumDigits(2)) u_legacy (
        .clk_i(clk), .rst_i(rst), .binary_i(bin1), .valid_i(vin1),
        .ready_o(rdy1), .bcd_o(bcd1), .valid_o(vld1), .ready_i(rin1)
    );

    bin2bcd_seq #(.BinWidth(16), .NumDigits(5)) u_wide (
        .clk_i(clk), .rst_i(rst), .binary_i(bin2), .valid_i(vin2),
        .ready_o(rdy2), .bcd_o(bcd2), .valid_o(vld2), .ready_i(rin2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decimal digits of v, one per nibble.
    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int unsigned ndig);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < ndig; i++) begin
            r = r | (64'(v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic rdy_of(input int w);
        case (w)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic vld_of(input int w);
        case (w)
            0:       return vld0;
            1:       return vld1;
            default: return vld2;
        endcase
    endfunction

    function automatic logic [63:0] bcd_of(input int w);
        case (w)
            0:       return 64'(bcd0);
            1:       return 64'(bcd1);
            default: return 64'(bcd2);
        endcase
    endfunction

    task automatic drive(input int w, input logic [63:0] val, input logic v);
        case (w)
            0:       begin bin0 = val[7:0];  vin0 = v; end
            1:       begin bin1 = val[3:0];  vin1 = v; end
            default: begin bin2 = val[15:0]; vin2 = v; end
        endcase
    endtask

    task automatic set_rin(input int w, input logic r);
        case (w)
            0:       rin0 = r;
            1:       rin1 = r;
            default: rin2 = r;
        endcase
    endtask

    // Waits (bounded) for valid_o at negedges; returns cycles since the accept edge.
    task automatic wait_valid(input int w, output int unsigned cyc);
        cyc = 0;
        while (vld_of(w) !== 1'b1 && cyc < bw[w] + 4) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
    task automatic do_conv(input int w, input longint unsigned val);
        int unsigned cyc;
        check($sformatf("ready_idle[%0d] v=%0d", w, val), 64'(rdy_of(w)), 64'd1);
        set_rin(w, 1'b1);
        drive(w, 64'(val), 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(w, 64'($urandom), 1'b0);
        wait_valid(w, cyc);
        check($sformatf("latency[%0d] v=%0d", w, val), 64'(cyc), 64'(bw[w]));
        check($sformatf("bcd[%0d] v=%0d", w, val), bcd_of(w), ref_bcd(val, nd[w]));
        check($sformatf("ready_done[%0d] v=%0d", w, val), 64'(rdy_of(w)), 64'd0);
        @(negedge clk);
        check($sformatf("back_idle[%0d] v=%0d", w, val), 64'({vld_of(w), rdy_of(w)}), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned cyc;
        int unsigned seen;
        rst = 1'b1;
        bin0 = '0; bin1 = '0; bin2 = '0;
        vin0 = 1'b0; vin1 = 1'b0; vin2 = 1'b0;
        rin0 = 1'b1; rin1 = 1'b1; rin2 = 1'b1;

        // Reset values before any clock edge
        #2;
        check("reset_ready", 64'(rdy0), 64'd1);
        check("reset_valid", 64'(vld0), 64'd0);
        check("reset_bcd", bcd_of(0), 64'h000);
        @(negedge clk);
        rst = 1'b0;

        // Default configuration: exhaustive, then random back-to-back
        for (int unsigned v = 0; v < 256; v++) do_conv(0, v);
        for (int i = 0; i < 20; i++) do_conv(0, $urandom_range(0, 255));

        // Legacy configuration
        for (int unsigned v = 0; v < 16; v++) do_conv(1, v);

        // Wide configuration
        do_conv(2, 65535);
        do_conv(2, 1000);
        do_conv(2, 0);
        for (int i = 0; i < 20; i++) do_conv(2, $urandom_range(0, 65535));

        // Backpressure: result held while consumer stalls, source noise ignored
        set_rin(0, 1'b0);
        drive(0, 64'd173, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 64'd42, 1'b0);
        wait_valid(0, cyc);
        check("bp_latency", 64'(cyc), 64'd8);
        for (int i = 0; i < 20; i++) begin
            drive(0, 64'd42, logic'(i % 2));
            @(negedge clk);
            check($sformatf("bp_valid c%0d", i), 64'(vld0), 64'd1);
            check($sformatf("bp_bcd c%0d", i), bcd_of(0), 64'h173);
            check($sformatf("bp_ready c%0d", i), 64'(rdy0), 64'd0);
        end
        drive(0, 64'd42, 1'b0);
        set_rin(0, 1'b1);
        @(negedge clk);
        check("bp_release_state", 64'({vld0, rdy0}), 64'd1);
        check("bp_bcd_kept", bcd_of(0), 64'h173);
        @(negedge clk);
        check("bp_no_accept", 64'(rdy0), 64'd1);

        // Reset mid-operation: 200 discarded after 4 SHIFT edges
        drive(0, 64'd200, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 64'd0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", 64'(rdy0), 64'd1);
        check("midrst_valid", 64'(vld0), 64'd0);
        check("midrst_bcd", bcd_of(0), 64'h000);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (vld0 !== 1'b0) seen++;
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (vld0 !== 1'b0) seen++;
        end
        check("midrst_no_valid", 64'(seen), 64'd0);
        check("midrst_bcd_after", bcd_of(0), 64'h000);
        do_conv(0, 7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It generalises the team's 4-bit combinational encoder to any binary width, with a configurable number of BCD digits, and uses one adjust/shift step per clock. It sits between binary datapath producers (counters, ALU results) and decimal display/readout logic. Both sides use valid/ready handshakes, so the block can be stalled from either side.

## Interface
- `BinWidth`, default 8: width of the binary input. Legal range is 1 to 32.
- `NumDigits`, default 3: number of BCD output digits. Elaboration must fail unless 10^NumDigits > 2^BinWidth − 1.
- `clk_i`  in  1: clock. All state updates on the rising edge.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `binary_i`  in  BinWidth: unsigned binary operand.
- `valid_i`  in  1: `binary_i` is valid.
- `ready_o`  out  1: block can accept an operand.
- `bcd_o`  out  4·NumDigits: packed BCD result. Digit k is `bcd_o[4k+3:4k]`, with digit 0 the least significant.
- `valid_o`  out  1: `bcd_o` holds a completed result.
- `ready_i`  in  1: consumer accepts the result.

## Operation
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - `ready_o` = 1.
  - On an edge with `valid_i` = 1, the block captures `binary_i` into the shift register, clears the BCD scratch register, loads the iteration counter with BinWidth, and moves to SHIFT.
- SHIFT:
  - `ready_o` = 0.
  - Each edge, in order: every scratch digit ≥ 5 gets +3. Then {scratch, shift register} shifts left by 1. Then the counter decrements.
  - On the edge where the counter goes 1 → 0, the final shifted scratch value is written to `bcd_o` and the FSM moves to DONE.
- DONE:
  - `valid_o` = 1 and `bcd_o` is stable.
  - On an edge with `ready_i` = 1, the FSM returns to IDLE.
  - `valid_i` is ignored in DONE; `ready_o` = 0.
- `bcd_o` is a dedicated output register. It keeps the last result after the handshake until the next result is written. The scratch register is never visible on `bcd_o`.
- Arithmetic:
  - The adjust step works per digit on 4 bits.
  - With NumDigits sized legally, no digit ever exceeds 9 after the final shift. Bits shifted out of the top digit are always zero.
- `ready_o` and `valid_o` are decoded from FSM state only. There are no combinational paths from `valid_i` or `ready_i`.

## Timing
- Reset values:
  - State = IDLE.
  - `ready_o` = 1, `valid_o` = 0, `bcd_o` = 0.
  - Scratch, shift register and counter = 0.
- Latency: the operand is accepted at edge T0, the SHIFT edges are T1…T_BinWidth, and `valid_o` is 1 in the cycle after T_BinWidth.
  - Total latency is BinWidth cycles from the accepting edge to `valid_o`.
- Throughput: if `ready_i` is held at 1, one conversion takes BinWidth + 2 cycles.
  - Sequence is accept, BinWidth shifts, one DONE cycle, then IDLE.
  - IDLE can accept on its first cycle.
- Backpressure: with `ready_i` = 0, DONE holds indefinitely with `bcd_o` and `valid_o` unchanged.
- Source side: `binary_i` is sampled only at the accepting edge. Later changes to `binary_i` do not affect the conversion in progress.
- Reset mid-operation: asserting `rst_i` in any state immediately forces the reset values.
  - The in-flight conversion is discarded and no `valid_o` pulse is produced.
  - The first edge after deassertion may accept a new operand.
- Boundary values:
  - BinWidth = 1 takes one SHIFT cycle.
  - Input 0 yields all-zero BCD. Input 2^BinWidth − 1 yields the full decimal value.

## Test plan
- **Reset:** assert `rst_i` with no clock → `ready_o` = 1, `valid_o` = 0, `bcd_o` = 0x000.
- **Default parameters, exhaustive:** drive `binary_i` = 0…255 with `ready_i` = 1.
  - Every result must match the decimal value, e.g. 9 → 0x009, 10 → 0x010, 99 → 0x099, 255 → 0x255.
  - `valid_o` must rise exactly 8 cycles after each accept.
  - Each conversion must take 10 cycles.
- **Backpressure:** convert 173 with `ready_i` = 0 for 20 cycles.
  - `valid_o` and `bcd_o` = 0x173 must stay stable, and `ready_o` = 0 throughout.
  - Changing `binary_i` to 42 and toggling `valid_i` meanwhile has no effect.
  - Releasing `ready_i` returns the FSM to IDLE.
- **Reset mid-operation:** accept 200, assert `rst_i` after 4 SHIFT cycles.
  - `valid_o` must never assert and `bcd_o` = 0x000.
  - After release, converting 7 → 0x007.
- **Legacy configuration:** BinWidth = 4, NumDigits = 2, inputs 0…15 → 0x00…0x15.
  - For example 12 → 0x12; the tens digit equals the old carry.
  - Latency is 4 cycles.
- **Wide configuration:** BinWidth = 16, NumDigits = 5.
  - 65535 → 0x65535, 1000 → 0x01000, 0 → 0x00000.
  - Latency is 16 cycles.
